// File: rtl/fifo_rd_unpack_pkg.sv
// Shared types, default widths and the clog2 helper for the FIFO read-side unpacker.
// Everything elaboration-time lives here so the top and the word register agree on it.
package fifo_rd_unpack_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_OW = 8;
  localparam int DEF_CW = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } hold_state_e;

  // Ceiling log2 that is usable in localparam expressions; myclog2(1) is 0.
  function automatic int myclog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Beat index width: never narrower than one bit, even when a word is a single beat.
  function automatic int beat_width(input int ratio);
    return (myclog2(ratio) < 1) ? 1 : myclog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_rd_unpack_reg_enrs.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
// Holds the popped FIFO word while its beats are streamed out.
module fifo_rd_unpack_reg_enrs #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fifo_rd_unpack.sv
// Read-side engine for a CDC FIFO: pops DW-bit words and streams them out as
// RATIO = DW/OW beats, LSB slice first, marking the final beat of each word.
module fifo_rd_unpack
  import fifo_rd_unpack_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int OW = DEF_OW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_rd,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic [CW-1:0] word_cnt
);

  localparam int            RATIO     = DW / OW;
  localparam int            BW        = beat_width(RATIO);
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  if ((DW % OW) != 0 || RATIO < 1) begin : g_bad_widths
    $error("fifo_rd_unpack: DW must be a non-zero multiple of OW");
  end

  hold_state_e   state_q;
  hold_state_e   state_d;
  logic [BW-1:0] beat_q;
  logic [BW-1:0] beat_d;
  logic [DW-1:0] word_q;
  logic [CW-1:0] word_cnt_q;
  logic          is_last;
  logic          acc;
  logic          fin;
  logic          pop;

  assign is_last = (beat_q == LAST_BEAT);
  assign acc     = out_valid & out_ready;
  assign fin     = acc & is_last;

  // A new word may be taken when nothing is held, or when the held word's last
  // beat leaves this very cycle; that overlap is what removes the bubble between words.
  assign pop     = rst_n & ~fifo_empty & ~flush & ((state_q == EMPTY) | fin);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (flush) begin
      state_d = EMPTY;
      beat_d  = '0;
    end else if (pop) begin
      state_d = HOLD;
      beat_d  = '0;
    end else if (fin) begin
      state_d = EMPTY;
      beat_d  = '0;
    end else if (acc) begin
      beat_d  = beat_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
    end else if (pop) begin
      word_cnt_q <= word_cnt_q + CW'(1);
    end
  end

  fifo_rd_unpack_reg_enrs #(
    .W       (DW),
    .RST_VAL ('0)
  ) u_word_q (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pop),
    .d     (fifo_data),
    .q     (word_q)
  );

  // Explicit slice mux keeps the select in range even for the single-beat case.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (beat_q == BW'(i)) out_data = word_q[i*OW +: OW];
    end
  end

  assign fifo_rd   = pop;
  assign out_valid = (state_q == HOLD);
  assign out_last  = (state_q == HOLD) & is_last;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Directed self-checking bench: a 4-beat unpacker (DW=32, OW=8) and a 1-beat one
// (DW=32, OW=32), each fed from a queue that behaves like the FIFO read port.
module tb_fifo_rd_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        fifo_empty_a, fifo_rd_a, flush_a, out_valid_a, out_ready_a, out_last_a;
  logic [31:0] fifo_data_a;
  logic [7:0]  out_data_a;
  logic [15:0] word_cnt_a;

  logic        fifo_empty_b, fifo_rd_b, flush_b, out_valid_b, out_ready_b, out_last_b;
  logic [31:0] fifo_data_b;
  logic [31:0] out_data_b;
  logic [15:0] word_cnt_b;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          pops_a;
  int          pops_b;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  stream_exp [12];
  logic [31:0] r1_words [8];

  always #5 clk = ~clk;

  fifo_rd_unpack #(.DW(32), .OW(8), .CW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty_a), .fifo_data(fifo_data_a),
    .fifo_rd(fifo_rd_a), .flush(flush_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_last(out_last_a), .word_cnt(word_cnt_a)
  );

  fifo_rd_unpack #(.DW(32), .OW(32), .CW(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty_b), .fifo_data(fifo_data_b),
    .fifo_rd(fifo_rd_b), .flush(flush_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_last(out_last_b), .word_cnt(word_cnt_b)
  );

  // Present the queue heads as FIFO flags/data and let combinational outputs settle.
  task automatic settle();
    fifo_empty_a = (qa.size() == 0);
    fifo_data_a  = (qa.size() != 0) ? qa[0] : 32'h0;
    fifo_empty_b = (qb.size() == 0);
    fifo_data_b  = (qb.size() != 0) ? qb[0] : 32'h0;
    #1;
  endtask

  // One clock: remember which pops were requested, pop the model queues, re-settle after negedge.
  task automatic clk_all();
    logic ra, rb;
    ra = fifo_rd_a;
    rb = fifo_rd_b;
    @(posedge clk);
    if (ra && qa.size() != 0) begin void'(qa.pop_front()); pops_a++; end
    if (rb && qb.size() != 0) begin void'(qb.pop_front()); pops_b++; end
    @(negedge clk);
    settle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_a = 1'b0; flush_b = 1'b0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    qa.delete(); qb.delete();
    settle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pops_a = 0; pops_b = 0;
    settle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    qa.push_back(32'hDEADBEEF);
    qb.push_back(32'hCAFEF00D);
    settle();
    for (int c = 0; c < 2; c++) begin
      vectors++; if (fifo_rd_a !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_a[%0d]: got %b want 0", c, fifo_rd_a); end
      vectors++; if (fifo_rd_b !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_b[%0d]: got %b want 0", c, fifo_rd_b); end
      vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid[%0d]: got %b want 0", c, out_valid_a); end
      vectors++; if (out_last_a !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_last[%0d]: got %b want 0", c, out_last_a); end
      vectors++; if (out_data_a !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data[%0d]: got %h want 00", c, out_data_a); end
      vectors++; if (word_cnt_a !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_cnt[%0d]: got %0d want 0", c, word_cnt_a); end
      @(posedge clk);
      @(negedge clk);
      settle();
    end
    do_reset();
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    do_reset();
    qa.push_back(32'hA1B2C3D4);
    settle();
    vectors++; if (fifo_rd_a !== 1'b1) begin miscompares++; $display("[TB] FAIL single_pop: got %b want 1", fifo_rd_a); end
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("[TB] FAIL single_pre_valid: got %b want 0", out_valid_a); end
    clk_all();
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_valid_a !== 1'b1) begin miscompares++; $display("[TB] FAIL single_valid[%0d]: got %b want 1", i, out_valid_a); end
      vectors++; if (out_data_a !== exp_b[i]) begin miscompares++; $display("[TB] FAIL single_data[%0d]: got %h want %h", i, out_data_a, exp_b[i]); end
      vectors++; if (out_last_a !== (i == 3)) begin miscompares++; $display("[TB] FAIL single_last[%0d]: got %b want %b", i, out_last_a, (i == 3)); end
      clk_all();
    end
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("[TB] FAIL single_post_valid: got %b want 0", out_valid_a); end
    vectors++; if (word_cnt_a !== 16'd1) begin miscompares++; $display("[TB] FAIL single_cnt: got %0d want 1", word_cnt_a); end
    vectors++; if (pops_a !== 1) begin miscompares++; $display("[TB] FAIL single_pops: got %0d want 1", pops_a); end
  endtask

  task automatic test_back_to_back();
    stream_exp = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'hCC, 8'hBB, 8'hAA, 8'h99};
    do_reset();
    qa.push_back(32'h11223344);
    qa.push_back(32'h55667788);
    qa.push_back(32'h99AABBCC);
    settle();
    clk_all();
    for (int i = 0; i < 12; i++) begin
      vectors++; if (out_valid_a !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_valid[%0d]: got %b want 1", i, out_valid_a); end
      vectors++; if (out_data_a !== stream_exp[i]) begin miscompares++; $display("[TB] FAIL stream_data[%0d]: got %h want %h", i, out_data_a, stream_exp[i]); end
      vectors++; if (out_last_a !== ((i % 4) == 3)) begin miscompares++; $display("[TB] FAIL stream_last[%0d]: got %b want %b", i, out_last_a, ((i % 4) == 3)); end
      vectors++; if (fifo_rd_a !== (i == 3 || i == 7)) begin miscompares++; $display("[TB] FAIL stream_rd[%0d]: got %b want %b", i, fifo_rd_a, (i == 3 || i == 7)); end
      clk_all();
    end
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_end_valid: got %b want 0", out_valid_a); end
    vectors++; if (word_cnt_a !== 16'd3) begin miscompares++; $display("[TB] FAIL stream_cnt: got %0d want 3", word_cnt_a); end
  endtask

  task automatic test_backpressure();
    do_reset();
    qa.push_back(32'hA1B2C3D4);
    settle();
    clk_all();
    clk_all();
    clk_all();
    qa.push_back(32'h0F0E0D0C);
    out_ready_a = 1'b0;
    settle();
    for (int c = 0; c < 5; c++) begin
      vectors++; if (out_valid_a !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_valid[%0d]: got %b want 1", c, out_valid_a); end
      vectors++; if (out_data_a !== 8'hB2) begin miscompares++; $display("[TB] FAIL bp_data[%0d]: got %h want b2", c, out_data_a); end
      vectors++; if (fifo_rd_a !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_rd[%0d]: got %b want 0", c, fifo_rd_a); end
      clk_all();
    end
    out_ready_a = 1'b1;
    settle();
    vectors++; if (out_data_a !== 8'hB2) begin miscompares++; $display("[TB] FAIL bp_resume_b2: got %h want b2", out_data_a); end
    clk_all();
    vectors++; if (out_data_a !== 8'hA1) begin miscompares++; $display("[TB] FAIL bp_resume_a1: got %h want a1", out_data_a); end
    vectors++; if (out_last_a !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_last: got %b want 1", out_last_a); end
    vectors++; if (fifo_rd_a !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_pop_at_last: got %b want 1", fifo_rd_a); end
    clk_all();
    vectors++; if (out_data_a !== 8'h0C) begin miscompares++; $display("[TB] FAIL bp_next_word: got %h want 0c", out_data_a); end
    vectors++; if (word_cnt_a !== 16'd2) begin miscompares++; $display("[TB] FAIL bp_cnt: got %0d want 2", word_cnt_a); end
  endtask

  task automatic test_flush();
    do_reset();
    qa.push_back(32'hA1B2C3D4);
    qa.push_back(32'hDDCCBBAA);
    settle();
    clk_all();
    clk_all();
    flush_a = 1'b1;
    settle();
    vectors++; if (out_data_a !== 8'hC3) begin miscompares++; $display("[TB] FAIL flush_at_beat1: got %h want c3", out_data_a); end
    vectors++; if (fifo_rd_a !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_no_pop: got %b want 0", fifo_rd_a); end
    clk_all();
    flush_a = 1'b0;
    settle();
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_valid: got %b want 0", out_valid_a); end
    vectors++; if (word_cnt_a !== 16'd1) begin miscompares++; $display("[TB] FAIL flush_cnt: got %0d want 1", word_cnt_a); end
    vectors++; if (fifo_rd_a !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_repop: got %b want 1", fifo_rd_a); end
    clk_all();
    vectors++; if (out_valid_a !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_new_valid: got %b want 1", out_valid_a); end
    vectors++; if (out_data_a !== 8'hAA) begin miscompares++; $display("[TB] FAIL flush_new_data: got %h want aa", out_data_a); end
    vectors++; if (word_cnt_a !== 16'd2) begin miscompares++; $display("[TB] FAIL flush_new_cnt: got %0d want 2", word_cnt_a); end
    clk_all();
    clk_all();
    clk_all();
    qa.push_back(32'h12345678);
    flush_a = 1'b1;
    settle();
    vectors++; if (out_last_a !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_fin_last: got %b want 1", out_last_a); end
    vectors++; if (fifo_rd_a !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_fin_no_pop: got %b want 0", fifo_rd_a); end
    clk_all();
    flush_a = 1'b0;
    settle();
    vectors++; if (out_valid_a !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_fin_valid: got %b want 0", out_valid_a); end
    vectors++; if (word_cnt_a !== 16'd2) begin miscompares++; $display("[TB] FAIL flush_fin_cnt: got %0d want 2", word_cnt_a); end
  endtask

  task automatic test_ratio_one();
    int   idx;
    logic exp_rd;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      r1_words[i] = 32'hC0DE0000 + 32'(i * 17);
      qb.push_back(r1_words[i]);
    end
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      out_ready_b = (c % 2 == 0);
      settle();
      exp_rd = (qb.size() != 0) && (!out_valid_b || out_ready_b);
      vectors++; if (fifo_rd_b !== exp_rd) begin miscompares++; $display("[TB] FAIL r1_rd[%0d]: got %b want %b", c, fifo_rd_b, exp_rd); end
      if (out_valid_b) begin
        vectors++; if (out_data_b !== r1_words[idx]) begin miscompares++; $display("[TB] FAIL r1_data[%0d]: got %h want %h", idx, out_data_b, r1_words[idx]); end
        vectors++; if (out_last_b !== 1'b1) begin miscompares++; $display("[TB] FAIL r1_last[%0d]: got %b want 1", idx, out_last_b); end
        if (out_ready_b) idx++;
      end
      clk_all();
    end
    vectors++; if (idx !== 8) begin miscompares++; $display("[TB] FAIL r1_accepts: got %0d want 8 (cycle budget)", idx); end
    vectors++; if (word_cnt_b !== 16'd8) begin miscompares++; $display("[TB] FAIL r1_cnt: got %0d want 8", word_cnt_b); end
    vectors++; if (pops_b !== 8) begin miscompares++; $display("[TB] FAIL r1_pops: got %0d want 8", pops_b); end
    out_ready_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      vectors++; if (fifo_rd_b !== 1'b0) begin miscompares++; $display("[TB] FAIL r1_empty_rd[%0d]: got %b want 0", c, fifo_rd_b); end
      vectors++; if (out_valid_b !== 1'b0) begin miscompares++; $display("[TB] FAIL r1_empty_valid[%0d]: got %b want 0", c, out_valid_b); end
      clk_all();
    end
  endtask

  initial begin
    flush_a = 1'b0; flush_b = 1'b0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    pops_a = 0; pops_b = 0;
    settle();
    #1 rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_ratio_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
